// File: rtl/serial_mant_adder.sv
// -----------------------------------------------------------------------------
// serial_mant_adder
//
// Bit-serial mantissa adder/subtractor. One result bit is produced per clock,
// LSB first, by a single full-adder cell (two half adders plus an OR). An
// operation takes WIDTH+1 rising edges from the edge that samples start to the
// edge after which done is high. Subtraction is A + ~B + 1, so C=1 means
// "no borrow".
//
// Parameters
//   WIDTH  mantissa width in bits (2..32)
//
// Ports
//   clk    single clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   start  begin an operation (sampled only in IDLE)
//   sub    0 = A+B, 1 = A-B (sampled with start)
//   A, B   unsigned operands (sampled with start)
//   busy   high while RUN or DONE
//   done   one-cycle pulse while the new result is presented
//   SUM    registered result, modulo 2^WIDTH
//   C      registered carry-out (bit WIDTH of the full result)
//   Z      registered flag, high when SUM is all zeros
// -----------------------------------------------------------------------------
module serial_mant_adder #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             C,
    output logic             Z
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    // Full-adder cell on the current LSBs: two half adders plus an OR.
    logic             ha_p;
    logic             ha_g1;
    logic             ha_g2;
    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    assign ha_p     = op_a[0] ^ op_b[0];
    assign ha_g1    = op_a[0] & op_b[0];
    assign s_bit    = ha_p ^ carry;
    assign ha_g2    = ha_p & carry;
    assign c_next   = ha_g1 | ha_g2;

    // Result bits enter at the MSB, so after WIDTH shifts bit 0 sits at [0].
    assign res_next = {s_bit, res_sh[WIDTH-1:1]};
    assign last_bit = (cnt == CW'(WIDTH - 1));

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)    state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:                  state_d = IDLE;
            default:               state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: operand shifters, carry, counter, result shifter, outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift registers are cleared too so an aborted operation leaves no residue.
            op_a   <= '0;
            op_b   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            SUM    <= '0;
            C      <= 1'b0;
            Z      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values of the others.
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_a  <= A;
                        op_b  <= sub ? ~B : B;
                        carry <= sub;          // the +1 of two's-complement negation
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= c_next;
                    res_sh <= res_next;
                    cnt    <= cnt + 1'b1;
                    if (last_bit) begin
                        SUM <= res_next;
                        C   <= c_next;
                        Z   <= (res_next == '0);
                    end
                end
                default: begin
                    // DONE: results are already registered, nothing moves.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mant_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_mant_adder
//
// Directed bench for serial_mant_adder at WIDTH=24. Expected values are
// hand-computed constants. Inputs change on the falling edge or 1 ns after the
// rising edge; outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/100ps

module tb_serial_mant_adder;

    localparam int WIDTH = 24;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] SUM;
    logic             C;
    logic             Z;

    int n_cmp = 0;
    int n_err = 0;

    serial_mant_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .SUM   (SUM),
        .C     (C),
        .Z     (Z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts rising edges until done is seen (sampled 1 ns after each edge).
    // Called just after the start edge, so a correct design returns WIDTH
    // (WIDTH+1 edges including the start edge). Bounded at 100 edges.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1;
        end while (!done && n < 100);
    endtask

    // One complete operation; operands are scrambled after the start edge to
    // show they are only sampled with start.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input logic [WIDTH-1:0] e_sum, input logic e_c,
                          input logic e_z);
        int n;
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A = ~a; B = ~b; sub = ~s;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        wait_done(n);
        chk({tag, "_lat"}, 32'(n), 32'(WIDTH));
        chk({tag, "_sum"}, 32'(SUM), 32'(e_sum));
        chk({tag, "_c"},   32'(C),   32'(e_c));
        chk({tag, "_z"},   32'(Z),   32'(e_z));
        @(posedge clk);
        #1;
        chk({tag, "_done_off"}, 32'(done), 32'd0);
        chk({tag, "_idle"},     32'(busy), 32'd0);
        chk({tag, "_hold"},     32'(SUM),  32'(e_sum));
    endtask

    initial begin
        int n;
        int pulses;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(SUM),  32'd0);
        chk("rst_c",    32'(C),    32'd0);
        chk("rst_z",    32'(Z),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap-around add, all-zero result.
        run_op("add_wrap", 24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1, 1'b1);
        // Subtraction without and with borrow.
        run_op("sub_pos",  24'h000005, 24'h000003, 1'b1, 24'h000002, 1'b1, 1'b0);
        run_op("sub_neg",  24'h000003, 24'h000005, 1'b1, 24'hFFFFFE, 1'b0, 1'b0);
        // Boundaries: equal operands, 0-1, max+max.
        run_op("sub_eq",   24'hABCDEF, 24'hABCDEF, 1'b1, 24'h000000, 1'b1, 1'b1);
        run_op("sub_zero", 24'h000000, 24'h000001, 1'b1, 24'hFFFFFF, 1'b0, 1'b0);
        run_op("add_max",  24'hFFFFFF, 24'hFFFFFF, 1'b0, 24'hFFFFFE, 1'b1, 1'b0);

        // start held high: back-to-back operations with one IDLE cycle between.
        @(negedge clk);
        A = 24'h800000; B = 24'h800000; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_busy0", 32'(busy), 32'd1);
        wait_done(n);
        chk("b2b_lat0", 32'(n),   32'(WIDTH));
        chk("b2b_sum0", 32'(SUM), 32'h000000);
        chk("b2b_c0",   32'(C),   32'd1);
        @(posedge clk);
        #1;
        chk("b2b_gap",  32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("b2b_busy1", 32'(busy), 32'd1);
        wait_done(n);
        chk("b2b_lat1", 32'(n),   32'(WIDTH));
        chk("b2b_sum1", 32'(SUM), 32'h000000);
        chk("b2b_c1",   32'(C),   32'd1);
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("b2b_stop", 32'(busy), 32'd0);

        // start and operand changes during RUN are ignored.
        @(negedge clk);
        A = 24'h123456; B = 24'h654321; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        A = 24'hFFFFFF; B = 24'hFFFFFF; sub = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        // 1 start edge + 4 + 1 edges already elapsed.
        wait_done(n);
        chk("ign_lat", 32'(n),   32'(WIDTH - 5));
        chk("ign_sum", 32'(SUM), 32'h777777);
        chk("ign_c",   32'(C),   32'd0);
        chk("ign_z",   32'(Z),   32'd0);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("ign_pulses", 32'(pulses), 32'd0);
        chk("ign_idle",   32'(busy),   32'd0);
        chk("ign_hold",   32'(SUM),    32'h777777);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        A = 24'h00000F; B = 24'h000001; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #0.5;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_sum",  32'(SUM),  32'd0);
        chk("arst_c",    32'(C),    32'd0);
        chk("arst_z",    32'(Z),    32'd0);
        #0.5;
        rst_n = 1'b1;
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) pulses++;
        end
        chk("arst_quiet", 32'(pulses), 32'd0);
        chk("arst_keep",  32'(SUM),    32'd0);
        run_op("after_rst", 24'h000001, 24'h000002, 1'b0, 24'h000003, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
